// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, one-entry skid buffer, IF/ID register.
// Optional IF_MISALIGN_CHK_EN: sticky fetch_misalign_o on a misaligned redirect target; otherwise targets are aligned down.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_i,
  input  logic [31:0] bt_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  logic [31:0] pc_q, pc_d;
  logic        outstanding_q, outstanding_d;
  logic        stale_q, stale_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  logic        redirect, halt;
  logic [31:0] tgt, fetch_addr;
  logic        rsp_hit, rsp_ok, skid_fill, slot_free, issue;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  logic bad_tgt;
  assign bad_tgt          = redirect && (bt_i[1:0] != 2'b00);
  assign tgt              = bt_i;
  assign halt             = misalign_q || bad_tgt;
  assign misalign_d       = misalign_q || bad_tgt;
  assign fetch_misalign_o = misalign_q;
`else
  assign tgt  = bt_i & ~32'h0000_0003;
  assign halt = 1'b0;
`endif

  assign redirect   = br_i && !stall_i;
  assign rsp_hit    = imem_rvalid_i && outstanding_q;
  assign rsp_ok     = rsp_hit && !stale_q && !redirect;
  assign skid_fill  = rsp_ok && stall_i && !skid_v_q;
  // Holding off the refill while the skid is being loaded keeps at most one response parked during a stall.
  assign slot_free  = redirect ? !outstanding_q : (!outstanding_q || imem_rvalid_i);
  assign issue      = !rst && !halt && slot_free && !(skid_v_q && stall_i) && !skid_fill;
  assign fetch_addr = redirect ? tgt : pc_q;

  assign imem_req_o  = issue;
  assign imem_addr_o = issue ? fetch_addr : '0;
  assign id_pc_o     = id_pc_q;
  assign id_inst_o   = id_inst_q;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    req_pc_d      = req_pc_q;
    skid_v_d      = skid_v_q;
    skid_pc_d     = skid_pc_q;
    skid_inst_d   = skid_inst_q;
    id_pc_d       = id_pc_q;
    id_inst_d     = id_inst_q;

    if (redirect) pc_d = tgt;
    if (issue) begin
      pc_d     = fetch_addr + 32'd4;
      req_pc_d = fetch_addr;
    end

    if (rsp_hit) outstanding_d = 1'b0;
    if (issue)   outstanding_d = 1'b1;

    if (rsp_hit) stale_d = 1'b0;
    if (redirect && outstanding_q && !imem_rvalid_i) stale_d = 1'b1;

    if (!stall_i) skid_v_d = 1'b0;
    if (skid_fill) begin
      skid_v_d    = 1'b1;
      skid_pc_d   = req_pc_q;
      skid_inst_d = imem_rdata_i;
    end

    if (redirect) begin
      id_pc_d   = '0;
      id_inst_d = '0;
    end else if (!stall_i) begin
      if (skid_v_q) begin
        id_pc_d   = skid_pc_q;
        id_inst_d = skid_inst_q;
      end else if (rsp_ok) begin
        id_pc_d   = req_pc_q;
        id_inst_d = imem_rdata_i;
      end else begin
        id_pc_d   = '0;
        id_inst_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= 1'b0;
      stale_q       <= 1'b0;
      req_pc_q      <= '0;
      skid_v_q      <= 1'b0;
      skid_pc_q     <= '0;
      skid_inst_q   <= '0;
      id_pc_q       <= '0;
      id_inst_q     <= '0;
`ifdef IF_MISALIGN_CHK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      req_pc_q      <= req_pc_d;
      skid_v_q      <= skid_v_d;
      skid_pc_q     <= skid_pc_d;
      skid_inst_q   <= skid_inst_d;
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
`ifdef IF_MISALIGN_CHK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a fixed-latency instruction memory returning addr+0x100.
// Covers IF_MISALIGN_CHK_EN in both build variants.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        br_i = 1'b0;
  logic [31:0] bt_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
`ifdef IF_MISALIGN_CHK_EN
  logic        fetch_misalign_o;
`endif

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .br_i             (br_i),
    .bt_i             (bt_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .id_pc_o          (id_pc_o),
    .id_inst_o        (id_inst_o)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .fetch_misalign_o (fetch_misalign_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One cycle: drive memory response and control inputs after the edge, capture any request at negedge.
  task automatic cyc(input logic st, input logic b, input logic [31:0] t);
    @(posedge clk);
    #1;
    rst = 1'b0;
    imem_rvalid_i = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = paddr + 32'h100;
        pend          = 1'b0;
      end
    end
    stall_i = st;
    br_i    = b;
    bt_i    = t;
    @(negedge clk);
    if (imem_req_o) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = imem_addr_o;
    end
  endtask

  task automatic do_reset(input int l);
    @(posedge clk);
    #1;
    rst = 1'b1;
    stall_i = 1'b0;
    br_i = 1'b0;
    imem_rvalid_i = 1'b0;
    pend = 1'b0;
    lat = l;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_inst", id_inst_o, 32'h0);
`ifdef IF_MISALIGN_CHK_EN
    chk("rst_mis", {31'b0, fetch_misalign_o}, 32'h0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1-cycle memory: streaming, stall with skid, branch under stall, redirect
    do_reset(1);
    cyc(0, 0, 0); chk("c0_req", {31'b0, imem_req_o}, 32'h1); chk("c0_addr", imem_addr_o, 32'h0);
    cyc(0, 0, 0); chk("c1_addr", imem_addr_o, 32'h4); chk("c1_inst", id_inst_o, 32'h0);
    cyc(0, 0, 0); chk("c2_addr", imem_addr_o, 32'h8); chk("c2_inst", id_inst_o, 32'h100);
    chk("c2_pc", id_pc_o, 32'h0);
    cyc(0, 0, 0); chk("c3_inst", id_inst_o, 32'h104); chk("c3_pc", id_pc_o, 32'h4);
    cyc(1, 0, 0); chk("st0_pc", id_pc_o, 32'h8); chk("st0_req", {31'b0, imem_req_o}, 32'h0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0); chk("st3_pc", id_pc_o, 32'h8); chk("st3_inst", id_inst_o, 32'h108);
    chk("st3_req", {31'b0, imem_req_o}, 32'h0);
    cyc(0, 0, 0); chk("rel_req", {31'b0, imem_req_o}, 32'h1); chk("rel_addr", imem_addr_o, 32'h10);
    cyc(0, 0, 0); chk("rel1_pc", id_pc_o, 32'hC); chk("rel1_inst", id_inst_o, 32'h10C);
    cyc(0, 0, 0); chk("rel2_pc", id_pc_o, 32'h10);
    cyc(1, 1, 32'h80); chk("bst_req", {31'b0, imem_req_o}, 32'h0); chk("bst_pc", id_pc_o, 32'h14);
    cyc(0, 0, 0); chk("bst1_addr", imem_addr_o, 32'h1C); chk("bst1_pc", id_pc_o, 32'h14);
    cyc(0, 0, 0); chk("bst2_pc", id_pc_o, 32'h18);
    cyc(0, 1, 32'h42); chk("br_req", {31'b0, imem_req_o}, 32'h0);
`ifdef IF_MISALIGN_CHK_EN
    cyc(0, 0, 0); chk("mis_flag", {31'b0, fetch_misalign_o}, 32'h1);
    chk("mis_req1", {31'b0, imem_req_o}, 32'h0); chk("mis_inst1", id_inst_o, 32'h0);
    cyc(0, 0, 0); chk("mis_req2", {31'b0, imem_req_o}, 32'h0);
    cyc(0, 0, 0); chk("mis_inst3", id_inst_o, 32'h0); chk("mis_req3", {31'b0, imem_req_o}, 32'h0);
`else
    cyc(0, 0, 0); chk("br1_req", {31'b0, imem_req_o}, 32'h1); chk("br1_addr", imem_addr_o, 32'h40);
    chk("br1_inst", id_inst_o, 32'h0);
    cyc(0, 0, 0); chk("br2_inst", id_inst_o, 32'h0);
    cyc(0, 0, 0); chk("br3_pc", id_pc_o, 32'h40); chk("br3_inst", id_inst_o, 32'h140);
`endif

    // 3-cycle memory: bubbles between words, redirect with request in flight
    do_reset(3);
    cyc(0, 0, 0); chk("l3_c0_addr", imem_addr_o, 32'h0);
    cyc(0, 0, 0); chk("l3_c1_req", {31'b0, imem_req_o}, 32'h0);
    cyc(0, 0, 0);
    cyc(0, 0, 0); chk("l3_c3_addr", imem_addr_o, 32'h4); chk("l3_c3_req", {31'b0, imem_req_o}, 32'h1);
    cyc(0, 0, 0); chk("l3_c4_pc", id_pc_o, 32'h0); chk("l3_c4_inst", id_inst_o, 32'h100);
    cyc(0, 0, 0); chk("l3_c5_inst", id_inst_o, 32'h0);
    cyc(0, 0, 0); chk("l3_c6_addr", imem_addr_o, 32'h8);
    cyc(0, 0, 0); chk("l3_c7_pc", id_pc_o, 32'h4); chk("l3_c7_inst", id_inst_o, 32'h104);
    cyc(0, 0, 0); chk("l3_c8_inst", id_inst_o, 32'h0);
    cyc(0, 0, 0); chk("l3_c9_addr", imem_addr_o, 32'hC);
    cyc(0, 1, 32'h40); chk("l3_br_req", {31'b0, imem_req_o}, 32'h0); chk("l3_br_pc", id_pc_o, 32'h8);
    cyc(0, 0, 0); chk("l3_b1_req", {31'b0, imem_req_o}, 32'h0); chk("l3_b1_inst", id_inst_o, 32'h0);
    cyc(0, 0, 0); chk("l3_b2_addr", imem_addr_o, 32'h40); chk("l3_b2_req", {31'b0, imem_req_o}, 32'h1);
    cyc(0, 0, 0); chk("l3_b3_inst", id_inst_o, 32'h0); chk("l3_b3_pc", id_pc_o, 32'h0);
    cyc(0, 0, 0);
    cyc(0, 0, 0); chk("l3_b5_inst", id_inst_o, 32'h0);
    cyc(0, 0, 0); chk("l3_b6_pc", id_pc_o, 32'h40); chk("l3_b6_inst", id_inst_o, 32'h140);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
